// File: rtl/pc_ras_if.sv
// Bus between the control unit and the program-counter block: next-PC
// controls going in, current/next PC and return-stack status coming out.
interface pc_ras_if #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   // PCWre is a plain enable with no handshake: when it is 1 at a rising
   // edge the PC and return stack advance; when it is 0 all state holds and
   // Call/Ret are ignored. The outputs are valid every cycle.
   logic              PCWre;
   logic [1:0]        PCSrc;
   logic [15:0]       Imm;
   logic [25:0]       JTarget;
   logic [ADDR_W-1:0] RegAddr;
   logic              Call;
   logic              Ret;

   logic [ADDR_W-1:0] Addr;
   logic [ADDR_W-1:0] PCPlus;
   logic [ADDR_W-1:0] NextAddr;
   logic [ADDR_W-1:0] RasTop;
   logic [CNT_W-1:0]  RasCount;
   logic              RasOverflow;
   logic              RasUnderflow;
   logic              Misalign;

   modport master (
      output PCWre, PCSrc, Imm, JTarget, RegAddr, Call, Ret,
      input  Addr, PCPlus, NextAddr, RasTop, RasCount,
             RasOverflow, RasUnderflow, Misalign
   );

   modport slave (
      input  PCWre, PCSrc, Imm, JTarget, RegAddr, Call, Ret,
      output Addr, PCPlus, NextAddr, RasTop, RasCount,
             RasOverflow, RasUnderflow, Misalign
   );
endinterface

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC selection, write enable and a circular
// return-address stack used for call/return prediction.
module pc_ras_unit #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
   parameter int                RAS_DEPTH   = 4,
   parameter int                INSTR_BYTES = 4
) (
   input logic     CLK,
   input logic     Reset,
   pc_ras_if.slave bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  sp_q;
   logic [CNT_W-1:0]  count_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              misalign_q;

   logic [ADDR_W-1:0] pc_plus;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] target;
   logic              ras_empty;
   logic              ras_full;
   logic [PTR_W-1:0]  top_idx;

   assign pc_plus   = addr_q + ADDR_W'(INSTR_BYTES);
   assign ras_empty = (count_q == '0);
   assign ras_full  = (count_q == CNT_W'(RAS_DEPTH));
   assign top_idx   = sp_q - PTR_W'(1);
   assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];

   // Select the raw next-PC target; a Ret with a non-empty stack wins.
   always_comb begin
      target = pc_plus;
      unique case (bus.PCSrc)
         2'b00: target = pc_plus;
         2'b01: target = pc_plus + {{(ADDR_W-18){bus.Imm[15]}}, bus.Imm, 2'b00};
         2'b10: target = {pc_plus[ADDR_W-1:28], bus.JTarget, 2'b00};
         2'b11: target = bus.RegAddr;
         default: target = pc_plus;
      endcase
      if (bus.Ret && !ras_empty) begin
         target = ras_top;
      end
   end

   // PC register, misalignment pulse and sticky stack flags.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         addr_q      <= RESET_ADDR;
         misalign_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.PCWre) begin
         addr_q     <= {target[ADDR_W-1:2], 2'b00};
         misalign_q <= (target[1:0] != 2'b00);
         if (bus.Call && !bus.Ret && ras_full) begin
            overflow_q <= 1'b1;
         end
         if (bus.Ret && ras_empty) begin
            underflow_q <= 1'b1;
         end
      end else begin
         misalign_q <= 1'b0;
      end
   end

   // Return stack: push on Call, pop on Ret, replace top on Call+Ret.
   // A push while full overwrites the oldest entry via pointer wrap-around.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sp_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_mem[i] <= '0;
         end
      end else if (bus.PCWre) begin
         if (bus.Call && bus.Ret && !ras_empty) begin
            ras_mem[top_idx] <= pc_plus;
         end else if (bus.Call) begin
            // Call alone, or Call+Ret on an empty stack: plain push.
            ras_mem[sp_q] <= pc_plus;
            sp_q          <= sp_q + PTR_W'(1);
            if (!ras_full) begin
               count_q <= count_q + CNT_W'(1);
            end
         end else if (bus.Ret && !ras_empty) begin
            sp_q    <= top_idx;
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   assign bus.Addr         = addr_q;
   assign bus.PCPlus       = pc_plus;
   assign bus.NextAddr     = {target[ADDR_W-1:2], 2'b00};
   assign bus.RasTop       = ras_top;
   assign bus.RasCount     = count_q;
   assign bus.RasOverflow  = overflow_q;
   assign bus.RasUnderflow = underflow_q;
   assign bus.Misalign     = misalign_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit with RESET_ADDR = 0x3000, RAS_DEPTH = 4.
module tb_pc_ras_unit;
   logic CLK;
   logic Reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   pc_ras_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

   pc_ras_unit #(
      .ADDR_W(32),
      .RESET_ADDR(32'h0000_3000),
      .RAS_DEPTH(4),
      .INSTR_BYTES(4)
   ) dut (
      .CLK(CLK),
      .Reset(Reset),
      .bus(bus)
   );

   // Clock and reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one rising edge, then settle just after it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [2:0] exp);
      chk(tag, {29'd0, bus.RasOverflow, bus.RasUnderflow, bus.Misalign}, {29'd0, exp});
   endtask

   // Load Addr through the register-indirect path (no Call/Ret).
   task automatic goto(input logic [31:0] a);
      bus.PCWre   = 1'b1;
      bus.PCSrc   = 2'b11;
      bus.RegAddr = a;
      bus.Call    = 1'b0;
      bus.Ret     = 1'b0;
      step();
   endtask

   initial begin
      bus.PCWre   = 1'b0;
      bus.PCSrc   = 2'b00;
      bus.Imm     = 16'h0;
      bus.JTarget = 26'h0;
      bus.RegAddr = 32'h0;
      bus.Call    = 1'b0;
      bus.Ret     = 1'b0;
      Reset       = 1'b1;
      #2 Reset = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_addr", bus.Addr, 32'h0000_3000);
      chk("reset_count", 32'(bus.RasCount), 32'd0);
      chk_flags("reset_flags", 3'b000);
      Reset = 1'b1;
      step();
      chk("release_addr", bus.Addr, 32'h0000_3000);

      // Sequential fetch
      bus.PCWre = 1'b1;
      bus.PCSrc = 2'b00;
      repeat (3) step();
      chk("seq_addr", bus.Addr, 32'h0000_300C);
      chk("seq_pcplus", bus.PCPlus, 32'h0000_3010);

      // Backward branch then stall
      goto(32'h0000_0100);
      bus.PCSrc = 2'b01;
      bus.Imm   = 16'hFFFE;
      #1;
      chk("branch_next", bus.NextAddr, 32'h0000_00FC);
      step();
      chk("branch_addr", bus.Addr, 32'h0000_00FC);
      bus.PCWre = 1'b0;
      bus.Call  = 1'b1;
      repeat (2) step();
      chk("stall_addr", bus.Addr, 32'h0000_00FC);
      chk("stall_no_call", 32'(bus.RasCount), 32'd0);
      bus.Call = 1'b0;

      // Jump keeps upper PC nibble; misaligned register target
      goto(32'h4000_0010);
      bus.PCSrc   = 2'b10;
      bus.JTarget = 26'h0000040;
      step();
      chk("jump_addr", bus.Addr, 32'h4000_0100);
      bus.PCSrc   = 2'b11;
      bus.RegAddr = 32'h0000_0203;
      step();
      chk("reg_addr", bus.Addr, 32'h0000_0200);
      chk("misalign_set", 32'(bus.Misalign), 32'd1);
      bus.PCSrc = 2'b00;
      step();
      chk("misalign_clr", 32'(bus.Misalign), 32'd0);
      chk("after_mis_addr", bus.Addr, 32'h0000_0204);

      // Five calls into a 4-deep stack
      for (int k = 1; k <= 5; k++) begin
         goto(32'(k * 16));
         bus.PCSrc = 2'b00;
         bus.Call  = 1'b1;
         step();
         bus.Call = 1'b0;
         if (k == 4) chk_flags("no_ovf_at_4", 3'b000);
      end
      chk("ras_count_full", 32'(bus.RasCount), 32'd4);
      chk("ras_top_full", bus.RasTop, 32'h0000_0054);
      chk_flags("ovf_set", 3'b100);

      // Four returns pop newest-first
      bus.PCSrc = 2'b00;
      bus.Ret   = 1'b1;
      step();
      chk("ret1_addr", bus.Addr, 32'h0000_0054);
      chk("ret1_count", 32'(bus.RasCount), 32'd3);
      step();
      chk("ret2_addr", bus.Addr, 32'h0000_0044);
      step();
      chk("ret3_addr", bus.Addr, 32'h0000_0034);
      step();
      chk("ret4_addr", bus.Addr, 32'h0000_0024);
      chk("ret4_count", 32'(bus.RasCount), 32'd0);
      chk("empty_top", bus.RasTop, 32'h0);

      // Return on empty stack falls back to PCSrc
      bus.PCSrc   = 2'b11;
      bus.RegAddr = 32'h0000_0600;
      #1;
      chk("udf_next", bus.NextAddr, 32'h0000_0600);
      step();
      chk("udf_addr", bus.Addr, 32'h0000_0600);
      chk("udf_count", 32'(bus.RasCount), 32'd0);
      chk_flags("udf_flags", 3'b110);
      bus.Ret = 1'b0;

      // Call and Ret on the same edge replace the top
      goto(32'h0000_0010);
      bus.PCSrc = 2'b00;
      bus.Call  = 1'b1;
      step();
      bus.Call = 1'b0;
      goto(32'h0000_0080);
      chk("cr_top_before", bus.RasTop, 32'h0000_0014);
      bus.PCSrc = 2'b00;
      bus.Call  = 1'b1;
      bus.Ret   = 1'b1;
      step();
      chk("cr_addr", bus.Addr, 32'h0000_0014);
      chk("cr_top", bus.RasTop, 32'h0000_0084);
      chk("cr_count", 32'(bus.RasCount), 32'd1);
      bus.Ret = 1'b0;

      // Two more pushes, then asynchronous reset between edges
      step();
      step();
      chk("pre_rst_count", 32'(bus.RasCount), 32'd3);
      bus.Call  = 1'b0;
      bus.PCWre = 1'b0;
      #2 Reset = 1'b0;
      #1;
      chk("async_addr", bus.Addr, 32'h0000_3000);
      chk("async_count", 32'(bus.RasCount), 32'd0);
      chk("async_top", bus.RasTop, 32'h0);
      chk_flags("async_flags", 3'b000);
      step();
      Reset = 1'b1;
      step();
      chk("post_rst_addr", bus.Addr, 32'h0000_3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter block for the next-generation CPU core. It replaces the plain PC register and adds:
- on-chip next-PC selection: sequential, branch, jump, register;
- a stall/write-enable;
- a circular return-address stack (RAS) for call/return prediction.
It sits between the control unit and instruction memory. Addr drives the instruction-memory address each cycle.

Parameters:
ADDR_W, 32, PC width in bits; must be >= 32.
RESET_ADDR, 32'h0000_0000, value loaded into Addr on reset.
RAS_DEPTH, 4, number of return-address stack entries; must be a power of two, >= 2.
INSTR_BYTES, 4, PC increment per sequential instruction.

Ports:
CLK  input  1  clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-low reset; 0 initialises the block.
PCWre  input  1  1 = update PC/RAS this edge; 0 = hold all state.
PCSrc  input  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 register.
Imm  input  16  branch word offset, signed.
JTarget  input  26  jump word target.
RegAddr  input  ADDR_W  register-indirect target.
Call  input  1  push return address (Addr+INSTR_BYTES) onto RAS.
Ret  input  1  return: next PC taken from RAS top, overrides PCSrc.
Addr  output  ADDR_W  current PC (registered).
PCPlus  output  ADDR_W  Addr+INSTR_BYTES (combinational).
NextAddr  output  ADDR_W  address to be loaded at next enabled edge (combinational).
RasTop  output  ADDR_W  current RAS top entry; 0 when empty.
RasCount  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
RasOverflow  output  1  sticky: a push occurred while full.
RasUnderflow  output  1  sticky: a Ret occurred while empty.
Misalign  output  1  registered one-cycle pulse: selected target had nonzero low 2 bits.

Behaviour:
- Reset=0, asynchronous, regardless of CLK:
  - Addr=RESET_ADDR, RasCount=0, stack pointer=0, all RAS entries=0;
  - RasOverflow=RasUnderflow=Misalign=0.
- Reset release takes effect at the first rising edge with Reset=1.
- PCWre=0: Addr, RAS contents, RasCount and sticky flags hold. Call/Ret are ignored. Misalign clears to 0.
- Next-target calculation (combinational, modulo 2^ADDR_W):
  - 00: PCPlus.
  - 01: PCPlus + (sign-extend(Imm) << 2).
  - 10: {PCPlus[ADDR_W-1:28], JTarget, 2'b00}.
  - 11: RegAddr.
  - Ret=1 and RasCount>0: RasTop, regardless of PCSrc.
  - Ret=1 and RasCount=0: target falls back to the PCSrc selection; RasUnderflow set.
- NextAddr = target with bits [1:0] forced to 00.
- Misalign <= 1 at an enabled edge if the raw target[1:0] != 00, else 0.
- Latency: Addr = NextAddr one enabled edge later. There is no bubble.
- RAS is a circular buffer indexed by a log2(RAS_DEPTH)-bit pointer sp; the top is entry[sp-1].
- Enabled edge, Call only:
  - write PCPlus to entry[sp], sp++;
  - if RasCount<RAS_DEPTH, RasCount++;
  - else overwrite the oldest entry (wrap-around), RasCount unchanged, RasOverflow <= 1.
- Enabled edge, Ret only, RasCount>0: sp--, RasCount--. The entry content is unchanged.
- Enabled edge, Call and Ret together:
  - NextAddr uses the old top;
  - the top entry is replaced with PCPlus; sp and RasCount are unchanged;
  - if empty, behaves as a push and sets RasUnderflow.
- Sticky flags clear only on reset.
- A reset asserted mid-stall or mid-sequence discards all RAS contents immediately.

Test Plan:
- Reset=0 with RESET_ADDR=32'h0000_3000, toggle CLK, release -> Addr=0x3000, RasCount=0, all flags 0. Then 3 edges with PCSrc=00 -> Addr=0x300C.
- Addr=0x100, PCSrc=01, Imm=16'hFFFE -> NextAddr=0x0FC, and Addr=0x0FC after the edge. Then PCWre=0 for 2 edges -> Addr stays 0x0FC.
- Addr=0x4000_0010, PCSrc=10, JTarget=26'h0000040 -> Addr=0x4000_0100. Then PCSrc=11, RegAddr=0x203 -> Addr=0x200, Misalign=1 for exactly one cycle.
- Five Calls from Addr 0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> RasCount=4, RasOverflow=1. Four Rets -> Addr sequence 0x54,0x44,0x34,0x24. A fifth Ret -> RasUnderflow=1, PCSrc target used.
- Call+Ret same edge at Addr=0x80 with RasTop=0x14 -> Addr=0x14, RasTop=0x84, RasCount unchanged.
- Reset pulsed asynchronously between edges with RasCount=3 -> Addr=RESET_ADDR and RasCount=0 immediately, before the next CLK edge.
